hamming_secded_codec: RTL and testbench

Pipelined, parametrised SECDED (single-error-correct, double-error-detect) Hamming codec for NPU memory and interconnect paths. It extends plain Hamming parity generation with an overall parity bit, a per-beat encode/decode mode, in-line single-bit correction and a valid/ready streaming interface. Optional saturating error counters are included. It sits between SRAM/buffer read-write ports and the datapath, with one codec instance per protected channel.

---
 rtl/hamming_ecc_pkg.sv | 18 +
 rtl/hamming_parity_gen.sv | 27 ++
 rtl/hamming_secded_codec.sv | 174 +++++++++++++++++
 tb/tb_hamming_secded_codec.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_ecc_pkg.sv
// Shared types and helpers for the SECDED Hamming codec.
package hamming_ecc_pkg;

  typedef enum logic {
    ECC_ENC = 1'b0,
    ECC_DEC = 1'b1
  } ecc_mode_e;

  typedef struct packed {
    logic sbe;
    logic dbe;
  } ecc_status_t;

  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming parity: parity bit k is the XOR of every data bit whose
// codeword position has bit k set; data fills the non-power-of-two positions.
module hamming_parity_gen
  import hamming_ecc_pkg::*;
#(
  parameter int DW = 512,
  parameter int PW = 10
) (
  input  logic [DW-1:0] data_i,
  output logic [PW-1:0] parity_o
);

  always_comb begin
    int di;
    parity_o = '0;
    di       = 0;
    for (int pos = 1; pos <= DW + PW; pos++) begin
      if (!is_pow2(pos)) begin
        for (int k = 0; k < PW; k++) begin
          if (pos[k]) parity_o[k] = parity_o[k] ^ data_i[di];
        end
        di++;
      end
    end
  end

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage SECDED Hamming encoder/decoder with valid/ready streaming.
// Define HAMMING_ECC_ERR_CNT_EN to build the saturating SBE/DBE counters.
module hamming_secded_codec
  import hamming_ecc_pkg::*;
#(
  parameter int DW = 512,
  parameter int PW = 10,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_mode,
  input  logic [DW-1:0] i_data,
  input  logic [PW:0]   i_parity,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [PW:0]   o_parity,
  output logic [PW-1:0] o_syndrome,
  output logic          o_sbe,
  output logic          o_dbe,
  input  logic          i_cnt_clr,
  output logic [CW-1:0] o_sbe_cnt,
  output logic [CW-1:0] o_dbe_cnt
);

  if ((1 << PW) < DW + PW + 1) begin : g_pw_check
    $error("hamming_secded_codec: PW too small for DW");
  end

  logic          adv;
  logic [PW-1:0] gen_par;

  logic          vld_p1_q;
  ecc_mode_e     mode_p1_q,  mode_p1_d;
  logic [DW-1:0] data_p1_q;
  logic [PW:0]   par_p1_q,   par_p1_d;
  logic [PW-1:0] syn_p1_q,   syn_p1_d;
  logic          ovr_p1_q,   ovr_p1_d;

  logic          vld_p2_q;
  logic [DW-1:0] data_p2_q,  data_p2_d;
  logic [PW:0]   par_p2_q;
  logic [PW-1:0] syn_p2_q;
  ecc_status_t   st_p2_q,    st_p2_d;
  logic [DW-1:0] corr_mask;

  // Both stages move as one; a stalled output freezes the whole pipe.
  assign adv     = !vld_p2_q || i_ready;
  assign o_ready = adv;

  hamming_parity_gen #(.DW(DW), .PW(PW)) u_parity_gen (
    .data_i   (i_data),
    .parity_o (gen_par)
  );

  // ---- stage 1: parity recompute, syndrome, overall check ----
  always_comb begin
    mode_p1_d = ecc_mode_e'(i_mode);
    ovr_p1_d  = (^i_data) ^ (^i_parity);
    if (mode_p1_d == ECC_DEC) begin
      syn_p1_d = gen_par ^ i_parity[PW-1:0];
      par_p1_d = i_parity;
    end else begin
      syn_p1_d = '0;
      par_p1_d = {(^i_data) ^ (^gen_par), gen_par};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1_q  <= 1'b0;
      mode_p1_q <= ECC_ENC;
      data_p1_q <= '0;
      par_p1_q  <= '0;
      syn_p1_q  <= '0;
      ovr_p1_q  <= 1'b0;
    end else if (adv) begin
      vld_p1_q  <= i_valid;
      mode_p1_q <= mode_p1_d;
      data_p1_q <= i_data;
      par_p1_q  <= par_p1_d;
      syn_p1_q  <= syn_p1_d;
      ovr_p1_q  <= ovr_p1_d;
    end
  end

  // ---- stage 2: syndrome decode and correction ----
  always_comb begin
    int di;
    corr_mask = '0;
    di        = 0;
    for (int pos = 1; pos <= DW + PW; pos++) begin
      if (!is_pow2(pos)) begin
        if (int'(syn_p1_q) == pos) corr_mask[di] = 1'b1;
        di++;
      end
    end
  end

  // Syndrome 0 or a power of two hits a check bit, so the mask stays zero.
  always_comb begin
    st_p2_d   = '0;
    data_p2_d = data_p1_q;
    if (mode_p1_q == ECC_DEC) begin
      if (ovr_p1_q) begin
        if (int'(syn_p1_q) > DW + PW) begin
          st_p2_d.dbe = 1'b1;
        end else begin
          st_p2_d.sbe = 1'b1;
          data_p2_d   = data_p1_q ^ corr_mask;
        end
      end else if (syn_p1_q != '0) begin
        st_p2_d.dbe = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      par_p2_q  <= '0;
      syn_p2_q  <= '0;
      st_p2_q   <= '0;
    end else if (adv) begin
      vld_p2_q  <= vld_p1_q;
      data_p2_q <= data_p2_d;
      par_p2_q  <= par_p1_q;
      syn_p2_q  <= syn_p1_q;
      st_p2_q   <= st_p2_d;
    end
  end

  assign o_valid    = vld_p2_q;
  assign o_data     = data_p2_q;
  assign o_parity   = par_p2_q;
  assign o_syndrome = syn_p2_q;
  assign o_sbe      = st_p2_q.sbe;
  assign o_dbe      = st_p2_q.dbe;

`ifdef HAMMING_ECC_ERR_CNT_EN
  logic [CW-1:0] sbe_cnt_q;
  logic [CW-1:0] dbe_cnt_q;
  logic          out_hs;

  assign out_hs = vld_p2_q && i_ready;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else if (i_cnt_clr) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else if (out_hs) begin
      if (st_p2_q.sbe && (sbe_cnt_q != '1)) sbe_cnt_q <= sbe_cnt_q + CW'(1);
      if (st_p2_q.dbe && (dbe_cnt_q != '1)) dbe_cnt_q <= dbe_cnt_q + CW'(1);
    end
  end

  assign o_sbe_cnt = sbe_cnt_q;
  assign o_dbe_cnt = dbe_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_cnt_clr;
  assign o_sbe_cnt      = {CW{1'b0}};
  assign o_dbe_cnt      = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Bench for hamming_secded_codec at DW=8, PW=4, CW=2 with a scoreboard monitor.
module tb_hamming_secded_codec;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam int CW = 2;
`ifdef HAMMING_ECC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [4:0] par;
    logic [3:0] syn;
    logic       sbe;
    logic       dbe;
  } exp_t;

  typedef struct {
    logic       mode;
    logic [7:0] d;
    logic [4:0] p;
    exp_t       e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          o_ready;
  logic          mode = 1'b0;
  logic [DW-1:0] din = '0;
  logic [PW:0]   pin = '0;
  logic          o_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] o_data;
  logic [PW:0]   o_parity;
  logic [PW-1:0] o_syndrome;
  logic          o_sbe, o_dbe;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] o_sbe_cnt, o_dbe_cnt;

  int   checks = 0, failures = 0, n_in = 0, n_out = 0;
  int   m_sbe = 0, m_dbe = 0;
  exp_t sb[$];
  exp_t cur_exp;
  bit   mon_en = 0, stall_prev = 0, rnd_done = 0;
  logic [7:0] pv_data;
  logic [4:0] pv_par;
  logic [3:0] pv_syn;
  logic       pv_sbe, pv_dbe, pv_valid;

  always #5 clk = ~clk;

  hamming_secded_codec #(.DW(DW), .PW(PW), .CW(CW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (in_valid),
    .o_ready    (o_ready),
    .i_mode     (mode),
    .i_data     (din),
    .i_parity   (pin),
    .o_valid    (o_valid),
    .i_ready    (out_ready),
    .o_data     (o_data),
    .o_parity   (o_parity),
    .o_syndrome (o_syndrome),
    .o_sbe      (o_sbe),
    .o_dbe      (o_dbe),
    .i_cnt_clr  (cnt_clr),
    .o_sbe_cnt  (o_sbe_cnt),
    .o_dbe_cnt  (o_dbe_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference codec built from an explicit position table (DW=8, PW=4).
  function automatic exp_t model(input logic m, input logic [7:0] d, input logic [4:0] p);
    int         pos [8];
    logic [3:0] g;
    logic       ov;
    int         s;
    exp_t       e;
    pos = '{3, 5, 6, 7, 9, 10, 11, 12};
    g = '0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++)
        if (((pos[i] >> k) & 1) == 1) g[k] = g[k] ^ d[i];
    e.data = d; e.syn = '0; e.sbe = 1'b0; e.dbe = 1'b0;
    if (!m) begin
      e.par = {(^d) ^ (^g), g};
    end else begin
      e.par = p;
      e.syn = g ^ p[3:0];
      ov    = (^d) ^ (^p);
      s     = int'(e.syn);
      if (ov) begin
        if (s > 12) e.dbe = 1'b1;
        else begin
          e.sbe = 1'b1;
          for (int i = 0; i < 8; i++) if (pos[i] == s) e.data[i] = ~d[i];
        end
      end else if (s != 0) e.dbe = 1'b1;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic m, input logic [7:0] d, input logic [4:0] p,
                              input logic [7:0] ed, input logic [4:0] ep, input logic [3:0] es,
                              input logic sbe, input logic dbe);
    vec_t v;
    v.mode = m; v.d = d; v.p = p;
    v.e.data = ed; v.e.par = ep; v.e.syn = es; v.e.sbe = sbe; v.e.dbe = dbe;
    return v;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic m, input logic [7:0] d, input logic [4:0] p, input exp_t e);
    bit acc = 0;
    cur_exp = e; mode = m; din = d; pin = p; in_valid = 1'b1;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk); acc = o_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin @(posedge clk); g++; end
    @(posedge clk); #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      chk("sbe_cnt", 32'(o_sbe_cnt), 32'(CNT_EN ? m_sbe : 0));
      chk("dbe_cnt", 32'(o_dbe_cnt), 32'(CNT_EN ? m_dbe : 0));
      if (stall_prev) begin
        chk("hold_valid", 32'(o_valid), 32'(pv_valid));
        chk("hold_data", 32'(o_data), 32'(pv_data));
        chk("hold_parity", 32'(o_parity), 32'(pv_par));
        chk("hold_syn", 32'(o_syndrome), 32'(pv_syn));
        chk("hold_flags", 32'({o_sbe, o_dbe}), 32'({pv_sbe, pv_dbe}));
      end
      if (o_valid && !out_ready) chk("ready_stall", 32'(o_ready), 32'd0);
      if (in_valid && o_ready) begin sb.push_back(cur_exp); n_in++; end
      if (cnt_clr) begin m_sbe = 0; m_dbe = 0; end
      if (o_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow actual=extra_beat expected=no_beat");
        end else begin
          e = sb.pop_front();
          chk("data", 32'(o_data), 32'(e.data));
          chk("parity", 32'(o_parity), 32'(e.par));
          chk("syndrome", 32'(o_syndrome), 32'(e.syn));
          chk("sbe", 32'(o_sbe), 32'(e.sbe));
          chk("dbe", 32'(o_dbe), 32'(e.dbe));
          if (!cnt_clr) begin
            if (e.sbe) m_sbe = (m_sbe == 3) ? 3 : m_sbe + 1;
            if (e.dbe) m_dbe = (m_dbe == 3) ? 3 : m_dbe + 1;
          end
        end
      end
      stall_prev = o_valid && !out_ready;
      pv_valid = o_valid; pv_data = o_data; pv_par = o_parity;
      pv_syn = o_syndrome; pv_sbe = o_sbe; pv_dbe = o_dbe;
    end
  end

  initial begin
    vec_t       tbl [11];
    logic [7:0] d;
    logic [12:0] cw;
    logic       m;
    int         nf;

    tbl[0]  = mk(1'b0, 8'hA5, 5'b11111, 8'hA5, 5'b00011, 4'h0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 8'h00, 5'b00000, 8'h00, 5'b00000, 4'h0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 8'hFF, 5'b01010, 8'hFF, 5'b00011, 4'h0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 8'h01, 5'b00000, 8'h01, 5'b10011, 4'h0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 8'hA5, 5'b00011, 8'hA5, 5'b00011, 4'h0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 8'hA4, 5'b00011, 8'hA5, 5'b00011, 4'h3, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 8'hA5, 5'b10011, 8'hA5, 5'b10011, 4'h0, 1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 8'hA6, 5'b00011, 8'hA6, 5'b00011, 4'h6, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 8'hA5, 5'b00010, 8'hA5, 5'b00010, 4'h1, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 8'hA5, 5'b01110, 8'hA5, 5'b01110, 4'hD, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 8'h7F, 5'b00011, 8'hFF, 5'b00011, 4'hC, 1'b1, 1'b0);

    // Reset state
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_parity", 32'(o_parity), 32'd0);
    chk("rst_syn", 32'(o_syndrome), 32'd0);
    chk("rst_flags", 32'({o_sbe, o_dbe}), 32'd0);
    chk("rst_cnts", 32'({o_sbe_cnt, o_dbe_cnt}), 32'd0);
    rst_n = 1'b1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    mon_en = 1;

    // Two-cycle latency
    cur_exp = tbl[0].e; mode = 1'b0; din = 8'hA5; pin = 5'b11111; in_valid = 1'b1;
    @(negedge clk); chk("lat_accept", 32'(o_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("lat_c1_valid", 32'(o_valid), 32'd0);
    @(negedge clk); chk("lat_c2_valid", 32'(o_valid), 32'd1);
    drain();

    for (int i = 0; i < 11; i++) send(tbl[i].mode, tbl[i].d, tbl[i].p, tbl[i].e);
    drain();

    // Mid-stream stall of three cycles
    fork
      begin
        send(1'b1, 8'hA4, 5'b00011, model(1'b1, 8'hA4, 5'b00011));
        send(1'b0, 8'h3C, 5'b00000, model(1'b0, 8'h3C, 5'b00000));
        send(1'b1, 8'hA6, 5'b00011, model(1'b1, 8'hA6, 5'b00011));
        send(1'b0, 8'hC3, 5'b00000, model(1'b0, 8'hC3, 5'b00000));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random beats with 0..2 flipped codeword bits and random backpressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          m  = 1'($urandom_range(0, 1));
          d  = 8'($urandom);
          cw = {model(1'b0, d, 5'd0).par, d};
          nf = int'($urandom_range(0, 2));
          for (int f = 0; f < nf; f++) cw[$urandom_range(0, 12)] ^= 1'b1;
          if (m) send(1'b1, cw[7:0], cw[12:8], model(1'b1, cw[7:0], cw[12:8]));
          else begin
            cw[12:8] = 5'($urandom);
            send(1'b0, d, cw[12:8], model(1'b0, d, cw[12:8]));
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Counter clear, saturation, and clear beating a same-cycle increment
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    chk("clr_sbe_cnt", 32'(o_sbe_cnt), 32'd0);
    chk("clr_dbe_cnt", 32'(o_dbe_cnt), 32'd0);
    for (int i = 0; i < 5; i++) send(1'b1, 8'hA4, 5'b00011, model(1'b1, 8'hA4, 5'b00011));
    drain();
    chk("sat_sbe_cnt", 32'(o_sbe_cnt), CNT_EN ? 32'd3 : 32'd0);
    chk("sat_dbe_cnt", 32'(o_dbe_cnt), 32'd0);
    cur_exp = model(1'b1, 8'hA4, 5'b00011);
    mode = 1'b1; din = 8'hA4; pin = 5'b00011; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(negedge clk); chk("clr_hs_valid", 32'(o_valid), 32'd1);
    @(posedge clk); #1 cnt_clr = 1'b0;
    chk("clr_wins_sbe", 32'(o_sbe_cnt), 32'd0);
    drain();

    // Asynchronous flush with beats in flight
    send(1'b0, 8'h11, 5'd0, model(1'b0, 8'h11, 5'd0));
    send(1'b0, 8'h22, 5'd0, model(1'b0, 8'h22, 5'd0));
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1 chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_data", 32'(o_data), 32'd0);
    n_in -= sb.size();
    sb.delete();
    m_sbe = 0; m_dbe = 0; stall_prev = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("flush_idle", 32'(o_valid), 32'd0);
    end
    @(posedge clk); #1;

    send(1'b1, 8'h7F, 5'b00011, tbl[10].e);
    drain();
    chk("beats_in_eq_out", 32'(n_out), 32'(n_in));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
